// File: rtl/up_bus_master.sv
// Single-outstanding initiator for the uP register bus: takes one command from a
// valid/ready stream, runs one read or write with a bus timeout, and returns the result.
module up_bus_master #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int BUS_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]   cmd_addr,
    input  logic [BUS_WIDTH*8-1:0]     cmd_wdata,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [BUS_WIDTH*8-1:0]     rsp_rdata,
    output logic                       rsp_error,

    output logic                       up_rreq,
    input  logic                       up_rack,
    output logic [ADDRESS_WIDTH-1:0]   up_raddr,
    input  logic [BUS_WIDTH*8-1:0]     up_rdata,

    output logic                       up_wreq,
    input  logic                       up_wack,
    output logic [ADDRESS_WIDTH-1:0]   up_waddr,
    output logic [BUS_WIDTH*8-1:0]     up_wdata,

    output logic [1:0]                 dbg_state
);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. rsp_* is
    // held stable while rsp_valid is high and not yet consumed.

    localparam int DW = BUS_WIDTH * 8;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]            wdata_q, wdata_d;
    logic                     write_q, write_d;
    logic [DW-1:0]            rdata_q, rdata_d;
    logic                     error_q, error_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     ack_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only the ack of the outstanding request type can complete it.
    assign ack_match = write_q ? up_wack : up_rack;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        error_d = error_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_write ? cmd_wdata : '0;
                    write_d = cmd_write;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // An ack in the last counted cycle wins over the timeout.
                if (ack_match) begin
                    rdata_d = write_q ? '0 : up_rdata;
                    error_d = 1'b0;
                    state_d = ST_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    error_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // cmd_ready is held low while rst is asserted so no command is taken during reset.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign up_rreq   = (state_q == ST_REQ) && !write_q;
    assign up_wreq   = (state_q == ST_REQ) && write_q;
    assign up_raddr  = addr_q;
    assign up_waddr  = addr_q;
    assign up_wdata  = wdata_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_up_bus_master.sv
// Directed self-checking bench for up_bus_master: write, read, timeout edges,
// backpressure, back-to-back, wrong/stray acks and reset mid-transaction.
module tb_up_bus_master;

    localparam int AW = 32;
    localparam int BW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic          up_rreq;
    logic          up_rack = 1'b0;
    logic [AW-1:0] up_raddr;
    logic [31:0]   up_rdata = '0;
    logic          up_wreq;
    logic          up_wack = 1'b0;
    logic [AW-1:0] up_waddr;
    logic [31:0]   up_wdata;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    up_bus_master #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .up_rreq  (up_rreq),
        .up_rack  (up_rack),
        .up_raddr (up_raddr),
        .up_rdata (up_rdata),
        .up_wreq  (up_wreq),
        .up_wack  (up_wack),
        .up_waddr (up_waddr),
        .up_wdata (up_wdata),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command and return in the cycle after acceptance (the REQ cycle).
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && w < 20) begin
            tick();
            w++;
        end
        check("issue_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("consume_rsp_low", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        int k;
        int start;
        logic [31:0] a;
        logic [31:0] d;

        // Reset
        tick();
        tick();
        check("reset_outputs",
              {cmd_ready, rsp_valid, rsp_error, rsp_rdata, up_rreq, up_wreq, up_raddr, up_wdata},
              '0);
        rst = 1'b0;
        #1;
        check("reset_ready", cmd_ready, 1'b1);
        tick();

        // Write with a one-cycle responder
        issue(1'b1, 32'h4, 32'hBE);
        check("wr_req", {up_wreq, up_rreq, up_waddr, up_wdata}, {1'b1, 1'b0, 32'h4, 32'hBE});
        tick();
        check("wr_req_one_cycle", {up_wreq, up_rreq}, 2'b00);
        up_wack = 1'b1;
        tick();
        up_wack = 1'b0;
        check("wr_rsp", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 32'h0});
        consume();

        // Read, rack three cycles after rreq
        issue(1'b0, 32'h8, 32'h0);
        check("rd_req", {up_rreq, up_wreq, up_raddr}, {1'b1, 1'b0, 32'h8});
        tick();
        check("rd_wait1", {up_rreq, rsp_valid, up_raddr}, {1'b0, 1'b0, 32'h8});
        tick();
        check("rd_wait2", {rsp_valid, up_raddr}, {1'b0, 32'h8});
        tick();
        check("rd_wait3", {rsp_valid, up_raddr}, {1'b0, 32'h8});
        up_rack  = 1'b1;
        up_rdata = 32'hDEADBEEF;
        tick();
        up_rack  = 1'b0;
        up_rdata = '0;
        check("rd_rsp", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
        consume();

        // Timeout with no responder: rsp_valid at N+18
        issue(1'b0, 32'h40, 32'h0);
        k = 1;
        while (!rsp_valid && k < 40) begin
            tick();
            k++;
        end
        check("to_latency", k, 18);
        check("to_rsp", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b1, 32'h0});
        consume();

        // Ack exactly at N+17 still completes normally
        issue(1'b0, 32'h44, 32'h0);
        k = 1;
        while (k < 17) begin
            tick();
            k++;
        end
        check("to_edge_pending", rsp_valid, 1'b0);
        up_rack  = 1'b1;
        up_rdata = 32'h12345678;
        tick();
        up_rack  = 1'b0;
        up_rdata = '0;
        check("to_edge_rsp", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 32'h12345678});
        consume();

        // Response backpressure with a pending command
        issue(1'b0, 32'h50, 32'h0);
        tick();
        up_rack  = 1'b1;
        up_rdata = 32'h5A5A1234;
        tick();
        up_rack  = 1'b0;
        up_rdata = '0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h60;
        cmd_wdata = 32'h77;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {rsp_valid, rsp_error, rsp_rdata, cmd_ready, up_rreq, up_wreq},
                  {1'b1, 1'b0, 32'h5A5A1234, 1'b0, 1'b0, 1'b0});
            tick();
        end
        cmd_valid = 1'b0;
        consume();

        // Four back-to-back reads, one per four cycles
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            a = 32'h100 + 32'(i) * 4;
            d = 32'hC0DE0000 + 32'(i);
            exp_q.push_back(d);
            check("b2b_ready", cmd_ready, 1'b1);
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = a;
            tick();
            cmd_valid = 1'b0;
            check("b2b_req", {up_rreq, up_raddr}, {1'b1, a});
            tick();
            up_rack  = 1'b1;
            up_rdata = d;
            tick();
            up_rack  = 1'b0;
            up_rdata = '0;
            rsp_ready = 1'b1;
            check("b2b_rsp", {rsp_valid, rsp_error, rsp_rdata, up_rreq}, {1'b1, 1'b0, exp_q.pop_front(), 1'b0});
            tick();
            rsp_ready = 1'b0;
        end
        check("b2b_cycles", cyc - start, 16);

        // Wrong acks during a write: wack in REQ and rack in WAIT are ignored
        issue(1'b1, 32'h70, 32'hA1);
        up_wack = 1'b1;
        tick();
        up_wack = 1'b0;
        up_rack = 1'b1;
        tick();
        tick();
        check("wrong_ack_pending", rsp_valid, 1'b0);
        up_rack = 1'b0;
        up_wack = 1'b1;
        tick();
        up_wack = 1'b0;
        check("wrong_ack_rsp", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 32'h0});
        consume();

        // Stray acks in IDLE
        up_rack  = 1'b1;
        up_wack  = 1'b1;
        up_rdata = 32'hFFFFFFFF;
        tick();
        tick();
        up_rack  = 1'b0;
        up_wack  = 1'b0;
        up_rdata = '0;
        check("stray_idle", {rsp_valid, up_rreq, up_wreq, cmd_ready}, 4'b0001);

        // Reset mid-WAIT, then a late rack
        issue(1'b0, 32'h80, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_outputs",
              {cmd_ready, rsp_valid, rsp_error, rsp_rdata, up_rreq, up_wreq, up_raddr, up_wdata},
              '0);
        rst = 1'b0;
        #1;
        check("midrst_ready", cmd_ready, 1'b1);
        up_rack  = 1'b1;
        up_rdata = 32'hBADBAD00;
        tick();
        up_rack  = 1'b0;
        up_rdata = '0;
        tick();
        check("midrst_no_rsp", {rsp_valid, rsp_rdata, cmd_ready}, {1'b0, 32'h0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/up_bus_master.md
Name: up_bus_master

Overview:
- Initiator for the team's uP register bus (up_rreq/up_rack/up_raddr/up_rdata, up_wreq/up_wack/up_waddr/up_wdata).
- Converts a valid/ready command stream into single bus transactions and returns each result on a valid/ready response stream.
- Lets FSMs, soft cores or bridges drive uP responders such as up_gpio, and lets benches drive them without hand-written stimulus.
- One transaction outstanding at a time, with a bus timeout so a missing responder cannot hang the initiator.

Parameters:
- ADDRESS_WIDTH, 32: width of cmd_addr, up_raddr and up_waddr.
- BUS_WIDTH, 4: data width in bytes; data buses are BUS_WIDTH*8 bits.
- TIMEOUT_CYCLES, 16: cycles to wait for an ack after a request; 0 disables the timeout.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_WIDTH  target address, passed to the bus unmodified.
- cmd_wdata  in  BUS_WIDTH*8  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  BUS_WIDTH*8  read data; 0 for writes and for errors.
- rsp_error  out  1  1 = timeout, no ack received.
- up_rreq  out  1  read request pulse.
- up_rack  in  1  read acknowledge.
- up_raddr  out  ADDRESS_WIDTH  read address.
- up_rdata  in  BUS_WIDTH*8  read data, valid in the up_rack cycle.
- up_wreq  out  1  write request pulse.
- up_wack  in  1  write acknowledge.
- up_waddr  out  ADDRESS_WIDTH  write address.
- up_wdata  out  BUS_WIDTH*8  write data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - All outputs go to 0, including cmd_ready, so cmd_ready is 1 from the first cycle after rst deasserts.
  - Reset mid-transaction drops the command silently: no response, any later ack is ignored.
- State machine: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_ready=1; all other outputs 0 except the address/data registers.
  - On accept in cycle N, register addr, wdata and write flag, then go to REQ.
- REQ (cycle N+1):
  - Exactly one of up_wreq or up_rreq is 1, for exactly this cycle.
  - up_waddr/up_wdata or up_raddr carry the registered values.
  - Address and data stay stable until leaving WAIT.
  - Clear the timeout counter, then go to WAIT.
  - An ack seen during REQ is ignored.
- WAIT:
  - Only the ack matching the request type counts: up_wack for a write, up_rack for a read. The other ack is ignored.
  - On the matching ack in cycle M: capture up_rdata (reads) or 0 (writes), set error=0, go to RESP. rsp_valid=1 from cycle M+1.
  - Without an ack the counter increments every cycle.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with no ack: rdata=0, error=1, go to RESP.
  - Net effect: an ack arriving at cycle N+1+TIMEOUT_CYCLES is still accepted; with no ack, rsp_valid rises at N+2+TIMEOUT_CYCLES.
  - Counter width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are held stable until the handshake.
  - On rsp_ready, go to IDLE, and rsp_valid=0 in the next cycle.
  - Back-to-back: the next command can be accepted in the cycle after the response handshake.
- Stray or late acks in IDLE, REQ or RESP have no effect.
- Minimum latency: accept at N, ack at N+2, rsp_valid at N+3. Throughput is at most one transaction per 4 cycles.
- cmd_ready never rises while rsp_valid=1. No new request is issued before the previous response is consumed.

Test Plan:
- Write, 1-cycle responder (up_gpio):
  - Stimulus: cmd write addr 0x4, data 0xBE.
  - Required: up_wreq high for exactly 1 cycle with up_waddr=0x4 and up_wdata=0xBE; rsp_valid 2 cycles after the request with error=0, rdata=0.
- Read, responder returning 0xDEADBEEF on rack 3 cycles after rreq:
  - Stimulus: cmd read addr 0x8.
  - Required: up_raddr held at 0x8 through WAIT; rsp_rdata=0xDEADBEEF, error=0.
- Timeout, TIMEOUT_CYCLES=16, no responder:
  - Stimulus: read accepted at cycle N.
  - Required: rsp_valid at N+18, error=1, rdata=0.
  - Repeat with the ack at exactly N+17: error=0.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles.
  - Required: rsp fields stable, cmd_ready=0, no further up_*req.
  - Then 4 back-to-back commands: each is issued only after the prior response handshake, in order.
- Wrong and stray acks:
  - up_rack during a write WAIT is ignored, and the transaction still completes on up_wack.
  - An ack pulse in IDLE produces no rsp_valid.
- Reset mid-WAIT:
  - Stimulus: assert rst for 1 cycle, then drive a late up_rack.
  - Required: all outputs 0, no response, cmd_ready=1 the cycle after rst deasserts.
